qspi_tx_shift_mlane: RTL

Parametrised successor to the fixed 32-bit quad transmit shifter. It accepts a DATA_W-bit word through a valid/ready handshake and serialises it onto the QSPI data lanes in single, dual or quad mode, with a selectable bit order. It drives per-lane output enables and a per-word done pulse. It sits between the QSPI controller FSM/TX FIFO and the pad ring.

---
 rtl/qspi_tx_shift_mlane.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/qspi_tx_shift_mlane.sv
// Multi-lane QSPI transmit shifter: serialises a DATA_W-bit word on 1, 2 or 4 lanes, MSB- or LSB-first.
// Define QSPI_TX_PRELOAD_EN to add a one-word holding register so consecutive words shift with no idle gap.
module qspi_tx_shift_mlane #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [1:0]        mode_i,
    input  logic              msb_first_i,
    output logic [3:0]        qsd_o,
    output logic [3:0]        qsd_oe_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] shreg, shreg_next;
    logic [1:0]        word_mode, word_mode_next;
    logic              word_msb, word_msb_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [3:0]        qsd_next, oe_next;
    logic              busy_next, done_next;
    logic              load;
    logic [DATA_W-1:0] load_data;
    logic [1:0]        load_mode;
    logic              load_msb;

    function automatic logic [3:0] lane_oe(input logic [1:0] m);
        case (m)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] last_beat(input logic [1:0] m);
        case (m)
            2'b00:   return CNT_W'(DATA_W - 1);
            2'b01:   return CNT_W'(DATA_W / 2 - 1);
            default: return CNT_W'(DATA_W / 4 - 1);
        endcase
    endfunction

    // The beat about to go out always sits at the end of the shift register that matches the bit order.
    function automatic logic [3:0] head_beat(input logic [DATA_W-1:0] w, input logic [1:0] m,
                                             input logic msb);
        logic [3:0] b;
        if (msb) begin
            case (m)
                2'b00:   b = {3'b000, w[DATA_W-1]};
                2'b01:   b = {2'b00, w[DATA_W-1 -: 2]};
                default: b = w[DATA_W-1 -: 4];
            endcase
        end else begin
            b = w[3:0] & lane_oe(m);
        end
        return b;
    endfunction

    function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w, input logic [1:0] m,
                                                     input logic msb);
        logic [DATA_W-1:0] s;
        case (m)
            2'b00:   s = msb ? (w << 1) : (w >> 1);
            2'b01:   s = msb ? (w << 2) : (w >> 2);
            default: s = msb ? (w << 4) : (w >> 4);
        endcase
        return s;
    endfunction

`ifdef QSPI_TX_PRELOAD_EN
    logic [DATA_W-1:0] hold_data;
    logic [1:0]        hold_mode;
    logic              hold_msb;
    logic              hold_full;
    logic              hold_wr, hold_rd;

    assign ready_o = (state == IDLE) || !hold_full;
    // On the last beat with an empty holding register, a new word bypasses it and loads directly.
    assign hold_wr = (state == SHIFT) && valid_i && !hold_full && (cnt != '0);
    assign hold_rd = (state == SHIFT) && hold_full && (cnt == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_data <= '0;
            hold_mode <= 2'b00;
            hold_msb  <= 1'b0;
            hold_full <= 1'b0;
        end else if (hold_wr) begin
            hold_data <= data_i;
            hold_mode <= mode_i;
            hold_msb  <= msb_first_i;
            hold_full <= 1'b1;
        end else if (hold_rd) begin
            hold_full <= 1'b0;
        end
    end
`else
    assign ready_o = (state == IDLE);
`endif

    always_comb begin
        state_next     = state;
        shreg_next     = shreg;
        word_mode_next = word_mode;
        word_msb_next  = word_msb;
        cnt_next       = cnt;
        qsd_next       = 4'b0000;
        oe_next        = 4'b0000;
        busy_next      = 1'b0;
        done_next      = 1'b0;
        load           = 1'b0;
        load_data      = data_i;
        load_mode      = mode_i;
        load_msb       = msb_first_i;

        case (state)
            IDLE: begin
                if (valid_i) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt != '0) begin
                    qsd_next   = head_beat(shreg, word_mode, word_msb);
                    oe_next    = lane_oe(word_mode);
                    busy_next  = 1'b1;
                    done_next  = (cnt == CNT_W'(1));
                    cnt_next   = cnt - CNT_W'(1);
                    shreg_next = shift_word(shreg, word_mode, word_msb);
                end else begin
`ifdef QSPI_TX_PRELOAD_EN
                    if (hold_full) begin
                        load      = 1'b1;
                        load_data = hold_data;
                        load_mode = hold_mode;
                        load_msb  = hold_msb;
                    end else if (valid_i) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
`else
                    state_next = IDLE;
`endif
                end
            end
            default: state_next = IDLE;
        endcase

        // Beat 0 is registered on the accepting edge; the shift register keeps the remaining beats.
        if (load) begin
            state_next     = SHIFT;
            qsd_next       = head_beat(load_data, load_mode, load_msb);
            oe_next        = lane_oe(load_mode);
            busy_next      = 1'b1;
            done_next      = 1'b0;
            cnt_next       = last_beat(load_mode);
            shreg_next     = shift_word(load_data, load_mode, load_msb);
            word_mode_next = load_mode;
            word_msb_next  = load_msb;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            shreg     <= '0;
            word_mode <= 2'b00;
            word_msb  <= 1'b0;
            cnt       <= '0;
            qsd_o     <= 4'b0000;
            qsd_oe_o  <= 4'b0000;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            state     <= state_next;
            shreg     <= shreg_next;
            word_mode <= word_mode_next;
            word_msb  <= word_msb_next;
            cnt       <= cnt_next;
            qsd_o     <= qsd_next;
            qsd_oe_o  <= oe_next;
            busy_o    <= busy_next;
            done_o    <= done_next;
        end
    end

endmodule
